// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state enum, master-ID type and default widths for the SDRAM arbiter
package sdram_arb_pkg;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BE_W = 2;
  localparam int MAX_PEND = 4;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  typedef logic id_t;
endpackage

// File: rtl/sdram_arb_id_fifo.sv
// sdram_arb_id_fifo: in-order read-ID FIFO; push_i/id_i write, pop_i advances, head_o/full_o/empty_o status
module sdram_arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_PEND
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  id_t  id_i,
  input  logic pop_i,
  output id_t  head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  id_t mem_q [DEPTH];
  logic do_push, do_pop;
  assign full_o = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & !full_o;
  assign do_pop = pop_i & !empty_o;
  assign head_o = mem_q[rp_q];
  always_comb begin
    wp_d = do_push ? wp_q + 1'b1 : wp_q;
    rp_d = do_pop ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wp_q] <= id_i;
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-master Avalon-MM arbiter; m0_*/m1_* masters, s_* SDRAM slave, err_rdv sticky orphan-data flag
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = sdram_arb_pkg::ADDR_W,
  parameter int DATA_W = sdram_arb_pkg::DATA_W,
  parameter int BE_W = sdram_arb_pkg::BE_W,
  parameter int MAX_PEND = sdram_arb_pkg::MAX_PEND
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_rdv
);
  state_e state_q, state_d;
  logic last_q, last_d, err_q, err_d;
  logic req0, req1, own, own1, sel_rd, sel_wr, sel_req, oth_req;
  logic accept, gw, full, empty;
  id_t head;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign own = state_q != IDLE;
  assign own1 = state_q == OWN1;
  assign sel_rd = own1 ? m1_read : m0_read;
  assign sel_wr = own1 ? m1_write : m0_write;
  assign sel_req = sel_rd | sel_wr;
  assign oth_req = own1 ? req0 : req1;
  assign s_address = own1 ? m1_address : m0_address;
  assign s_writedata = own1 ? m1_writedata : m0_writedata;
  assign s_byteenable = own1 ? m1_byteenable : m0_byteenable;
  // read wins over a simultaneous write; reads wait while the ID FIFO is full
  assign s_read = own & sel_rd & !full;
  assign s_write = own & sel_wr & !sel_rd;
  assign accept = (s_read | s_write) & !s_waitrequest;
  assign gw = s_waitrequest | (sel_rd & full) | !(s_read | s_write);
  assign m0_waitrequest = (state_q != OWN0) | gw;
  assign m1_waitrequest = !own1 | gw;
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign m0_readdatavalid = s_readdatavalid & !empty & !head;
  assign m1_readdatavalid = s_readdatavalid & !empty & head;
  assign err_rdv = err_q;
  sdram_arb_id_fifo #(.DEPTH(MAX_PEND)) u_fifo (
    .clk(clk_clk),
    .rst(reset_reset),
    .push_i(accept & s_read),
    .id_i(own1),
    .pop_i(s_readdatavalid),
    .head_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    err_d = err_q | (s_readdatavalid & empty);
    if (!own) begin
      state_d = (req0 & req1) ? (last_q ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    end else if (accept) begin
      last_d = own1;
      state_d = oth_req ? (own1 ? OWN0 : OWN1) : sel_req ? state_q : IDLE;
    end else if (!sel_req) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: table-driven and sequence checks of the two-master SDRAM arbiter
module tb_sdram_arbiter;
  logic clk_clk, reset_reset;
  logic [24:0] m0_address, m1_address, s_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, s_writedata, s_readdata;
  logic [1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic s_read, s_write, s_waitrequest, s_readdatavalid, err_rdv;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [5:0] in;
    logic [6:0] exp;
    logic [24:0] addr;
  } vec_t;
  vec_t tv [21];
  logic [6:0] got;
  sdram_arbiter dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_rdv(err_rdv)
  );
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk1(input string nm, input logic g, input logic e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, g, e);
    end
  endtask
  task automatic chkd(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, g, e);
    end
  endtask
  task automatic cyc(input logic m0r, input logic m1r, input logic [24:0] a0, input logic [24:0] a1,
                     input logic rdv, input logic [15:0] rd);
    @(negedge clk_clk);
    m0_read = m0r;
    m1_read = m1r;
    m0_write = 1'b0;
    m1_write = 1'b0;
    m0_address = a0;
    m1_address = a1;
    s_waitrequest = 1'b0;
    s_readdatavalid = rdv;
    s_readdata = rd;
    #1;
  endtask
  initial begin
    reset_reset = 1'b1;
    {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = '0;
    m0_address = 25'h10;
    m1_address = 25'h20;
    m0_writedata = 16'h1234;
    m1_writedata = 16'hBEEF;
    m0_byteenable = 2'b11;
    m1_byteenable = 2'b11;
    s_readdata = 16'h0;
    // in = {m0_read,m0_write,m1_read,m1_write,s_waitrequest,s_readdatavalid}
    // exp = {s_read,s_write,m0_wait,m1_wait,m0_rdv,m1_rdv,err_rdv}
    tv[0]  = '{6'b000000, 7'b0011000, 25'h0};
    tv[1]  = '{6'b010100, 7'b0011000, 25'h0};
    tv[2]  = '{6'b010100, 7'b0101000, 25'h10};
    tv[3]  = '{6'b010100, 7'b0110000, 25'h20};
    tv[4]  = '{6'b010100, 7'b0101000, 25'h10};
    tv[5]  = '{6'b010100, 7'b0110000, 25'h20};
    tv[6]  = '{6'b000000, 7'b0011000, 25'h0};
    tv[7]  = '{6'b010000, 7'b0011000, 25'h0};
    tv[8]  = '{6'b010000, 7'b0101000, 25'h10};
    tv[9]  = '{6'b000000, 7'b0011000, 25'h0};
    tv[10] = '{6'b001010, 7'b0011000, 25'h0};
    tv[11] = '{6'b011010, 7'b1011000, 25'h20};
    tv[12] = '{6'b011010, 7'b1011000, 25'h20};
    tv[13] = '{6'b011010, 7'b1011000, 25'h20};
    tv[14] = '{6'b011010, 7'b1011000, 25'h20};
    tv[15] = '{6'b011010, 7'b1011000, 25'h20};
    tv[16] = '{6'b011000, 7'b1010000, 25'h20};
    tv[17] = '{6'b010000, 7'b0101000, 25'h10};
    tv[18] = '{6'b000001, 7'b0011010, 25'h0};
    tv[19] = '{6'b000001, 7'b0011000, 25'h0};
    tv[20] = '{6'b000000, 7'b0011001, 25'h0};
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk_clk);
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = tv[i].in;
      s_readdata = 16'h5A5A;
      #1;
      got = {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, err_rdv};
      checks++;
      if (got !== tv[i].exp || ((tv[i].exp[6] | tv[i].exp[5]) && s_address !== tv[i].addr)) begin
        errors++;
        $display("FAIL vec%0d: got out=%b addr=%h expected out=%b addr=%h", i, got, s_address, tv[i].exp, tv[i].addr);
      end
    end
    @(negedge clk_clk);
    {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = '0;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    chk1("rst_err", err_rdv, 1'b0);
    chk1("rst_w0", m0_waitrequest, 1'b1);
    chk1("rst_w1", m1_waitrequest, 1'b1);
    cyc(1'b1, 1'b1, 25'h100, 25'h200, 1'b0, 16'h0);
    chk1("p0_idle_rd", s_read, 1'b0);
    cyc(1'b1, 1'b1, 25'h100, 25'h200, 1'b0, 16'h0);
    chk1("p1_rd", s_read, 1'b1);
    chkd("p1_addr", 32'(s_address), 32'h100);
    chk1("p1_w0", m0_waitrequest, 1'b0);
    cyc(1'b1, 1'b1, 25'h101, 25'h200, 1'b0, 16'h0);
    chkd("p2_addr", 32'(s_address), 32'h200);
    chk1("p2_w1", m1_waitrequest, 1'b0);
    cyc(1'b1, 1'b1, 25'h101, 25'h201, 1'b0, 16'h0);
    chkd("p3_addr", 32'(s_address), 32'h101);
    cyc(1'b1, 1'b1, 25'h102, 25'h201, 1'b0, 16'h0);
    chkd("p4_addr", 32'(s_address), 32'h201);
    cyc(1'b1, 1'b1, 25'h102, 25'h202, 1'b0, 16'h0);
    chk1("p5_full_blk", s_read, 1'b0);
    chk1("p5_full_w0", m0_waitrequest, 1'b1);
    cyc(1'b1, 1'b1, 25'h102, 25'h202, 1'b1, 16'hD100);
    chk1("p6_blk_on_pop", s_read, 1'b0);
    chk1("p6_rdv0", m0_readdatavalid, 1'b1);
    chk1("p6_rdv1", m1_readdatavalid, 1'b0);
    chkd("p6_data", 32'(m0_readdata), 32'hD100);
    cyc(1'b1, 1'b1, 25'h102, 25'h202, 1'b0, 16'h0);
    chk1("p7_rd", s_read, 1'b1);
    chkd("p7_addr", 32'(s_address), 32'h102);
    chk1("p7_w0", m0_waitrequest, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b1, 16'hD200);
    chk1("p8_rdv1", m1_readdatavalid, 1'b1);
    chk1("p8_rdv0", m0_readdatavalid, 1'b0);
    chkd("p8_data", 32'(m1_readdata), 32'hD200);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b1, 16'hD101);
    chk1("p9_rdv0", m0_readdatavalid, 1'b1);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b1, 16'hD201);
    chk1("p10_rdv1", m1_readdatavalid, 1'b1);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b1, 16'hD102);
    chk1("p11_rdv0", m0_readdatavalid, 1'b1);
    chk1("p11_rdv1", m1_readdatavalid, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b1, 16'h0);
    chk1("p12_orph0", m0_readdatavalid, 1'b0);
    chk1("p12_orph1", m1_readdatavalid, 1'b0);
    chk1("p12_err_pre", err_rdv, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b0, 16'h0);
    chk1("p13_err", err_rdv, 1'b1);
    cyc(1'b1, 1'b0, 25'h300, 25'h0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 25'h300, 25'h0, 1'b0, 16'h0);
    chk1("q1_rd", s_read, 1'b1);
    cyc(1'b1, 1'b0, 25'h301, 25'h0, 1'b0, 16'h0);
    chk1("q2_rd", s_read, 1'b1);
    @(negedge clk_clk);
    {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = '0;
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    chk1("q3_err", err_rdv, 1'b0);
    chk1("q3_w0", m0_waitrequest, 1'b1);
    chk1("q3_w1", m1_waitrequest, 1'b1);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b1, 16'h0);
    chk1("q4_rdv0", m0_readdatavalid, 1'b0);
    chk1("q4_rdv1", m1_readdatavalid, 1'b0);
    cyc(1'b0, 1'b0, 25'h0, 25'h0, 1'b0, 16'h0);
    chk1("q5_err", err_rdv, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
